i2c_frame_sequencer: RTL and testbench
======================================

# i2c_frame_sequencer

Sequences a multi-byte frame into the byte-wide `i2c_master_controller` of FPGA A. Latches an NBYTES-byte word on a start pulse and issues one write transaction per byte, MSB byte first, through the master's enable/ready handshake. Sits between the frame producer and the I2C master. Replaces ad-hoc bit/byte stepping with a single-clock FSM that has per-byte timeouts, abort, and done/error reporting.

## Interface
- NBYTES, 13: bytes per frame; frame width is 8*NBYTES.
- SLAVE_ADDR, 7'd7: 7-bit target address driven on m_addr.
- ACK_TIMEOUT, 64: maximum cycles from m_enable until m_ready falls.
- XFER_TIMEOUT, 4096: maximum cycles from m_ready falling until it rises again.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- frame_in  in  8*NBYTES  frame data; captured on an accepted start.
- abort  in  1  synchronous abort; highest priority after reset.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last byte completes.
- error  out  1  one-cycle pulse on timeout.
- byte_idx  out  $clog2(NBYTES)  index of the byte in flight; holds the failing index after an error.
- m_addr  out  7  constant SLAVE_ADDR.
- m_data  out  8  byte presented to the master.
- m_rw  out  1  constant 0 (write).
- m_enable  out  1  one-cycle transaction request to the master.
- m_ready  in  1  master idle/complete flag.

## Operation
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE, ERROR.
- **IDLE**
  - start=1 → capture frame_in into frame_q, byte_idx=0, go to ISSUE.
  - start while busy is ignored (not queued).
- **ISSUE**
  - Waits while m_ready=0.
  - When m_ready=1 → assert m_enable for exactly one cycle, clear the timer, go to WAIT_BUSY.
- **WAIT_BUSY**
  - m_ready=0 → clear the timer, go to WAIT_DONE.
  - Timer reaches ACK_TIMEOUT-1 → ERROR.
- **WAIT_DONE**
  - m_ready=1 and byte_idx==NBYTES-1 → DONE.
  - m_ready=1 otherwise → byte_idx+1, go to ISSUE.
  - Timer reaches XFER_TIMEOUT-1 → ERROR.
- **DONE:** done=1 for one cycle → IDLE.
- **ERROR:** error=1 for one cycle → IDLE. byte_idx is retained until the next accepted start.
- **Byte select:** m_data = frame_q[8*(NBYTES-1-byte_idx) +: 8]. Byte 0 is frame_q[8*NBYTES-1 -: 8].
  - m_data is valid from ISSUE onward.
  - m_data is stable through WAIT_DONE.
- **Abort:** in any state → IDLE next cycle.
  - No done or error pulse.
  - m_enable is deasserted in the same cycle.
  - A transaction already accepted by the master is not recalled.
- **Timer:** width $clog2(XFER_TIMEOUT). Saturates and does not wrap. Counts only in WAIT_BUSY and WAIT_DONE.
- **Priority:** rst > abort > timeout > m_ready transition.
  - If a timeout and m_ready arrive in the same cycle, the timeout wins.

## Timing
- **Reset values:** state=IDLE; busy, done, error, m_enable, m_rw, m_data, byte_idx all 0; m_addr=SLAVE_ADDR. frame_q and timer are cleared.
- **All outputs are registered.**
- **Start to first m_enable:** start in cycle N → ISSUE in N+1 → m_enable high in N+2 if m_ready=1.
- **Per-byte overhead:**
  - 2 cycles from m_ready rising to the next m_enable.
  - Frame time = NBYTES × (master transfer time + 3) + 2 cycles.
- **done timing:** done rises the cycle after m_ready rises on the last byte. busy falls one cycle later.
- **Frame capture:** frame_in is ignored after capture; it may change freely during a frame.

## Structure
- **Shared package `i2c_seq_pkg`:**
  - State enumeration (3-bit localparams).
  - Default SLAVE_ADDR, NBYTES, ACK_TIMEOUT, XFER_TIMEOUT.
  - Helper function `byte_sel(frame, idx)`.
- **Implementation:** single module with no sub-modules.
  - Timer and byte mux are inline.
  - The master is instantiated by the parent, not inside this block.

## Test plan
- **Nominal frame:** frame_in=0x0102…0D, bus-functional master that drops ready 1 cycle after enable and holds it low for 20 cycles.
  - m_data sequence 0x01…0x0D.
  - Exactly 13 m_enable pulses.
  - done once, at the cycle predicted by the frame-time formula.
- **Ready low at start:** master holds m_ready=0 for 50 cycles before the first byte → m_enable is withheld until m_ready=1; no error.
- **Ack timeout:** master ignores enable on byte 4 → error pulse after 64 cycles; byte_idx=4; busy=0; no done.
- **Transfer timeout:** master keeps ready low for 5000 cycles on byte 0 → error at 4096 cycles; the timer does not wrap.
- **Abort mid-frame:** abort in WAIT_DONE of byte 7 → IDLE next cycle; no done or error. A following start restarts at byte_idx=0 with the new frame.
- **Reset and ignored start:**
  - rst=0 for one cycle in ISSUE → every output takes its reset value on the next edge.
  - start while busy does not change frame_q.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types, defaults and helpers for the I2C frame sequencer.
package i2c_seq_pkg;

  localparam int         NBYTES_DEF       = 13;
  localparam logic [6:0] SLAVE_ADDR_DEF   = 7'd7;
  localparam int         ACK_TIMEOUT_DEF  = 64;
  localparam int         XFER_TIMEOUT_DEF = 4096;

  // Widest frame the byte selector handles; frames are zero-extended to this.
  localparam int MAX_NBYTES = 32;
  typedef logic [8*MAX_NBYTES-1:0] frame_max_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } seq_state_e;

  // Byte idx of an nbytes-wide frame, counted from the most significant byte.
  function automatic logic [7:0] byte_sel(input frame_max_t frame, input int idx,
                                          input int nbytes);
    return frame[8*(nbytes-1-idx) +: 8];
  endfunction

endpackage

// File: rtl/i2c_frame_sequencer.sv
// Streams an NBYTES frame, MSB byte first, into a byte-wide I2C master using
// its enable/ready handshake, with per-byte ack and transfer timeouts.
module i2c_frame_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int         NBYTES       = NBYTES_DEF,
  parameter logic [6:0] SLAVE_ADDR   = SLAVE_ADDR_DEF,
  parameter int         ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
  parameter int         XFER_TIMEOUT = XFER_TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [8*NBYTES-1:0]       frame_in,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [$clog2(NBYTES)-1:0] byte_idx,
  output logic [6:0]                m_addr,
  output logic [7:0]                m_data,
  output logic                      m_rw,
  output logic                      m_enable,
  input  logic                      m_ready
);

  localparam int IDX_W   = $clog2(NBYTES);
  localparam int FRAME_W = 8 * NBYTES;
  localparam int TMR_W   = $clog2(XFER_TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
  localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] XFER_LAST = TMR_W'(XFER_TIMEOUT - 1);

  seq_state_e         state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               m_enable_q, m_enable_d;
  logic [7:0]         m_data_q, m_data_d;
  logic [TMR_W-1:0]   timer_sat;
  frame_max_t         frame_ext;

  // Timer increment that sticks at all-ones instead of wrapping.
  assign timer_sat = (timer_q == '1) ? timer_q : timer_q + TMR_W'(1);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    frame_d    = frame_q;
    byte_idx_d = byte_idx_q;
    timer_d    = timer_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    m_enable_d = 1'b0;

    if (abort) begin
      // Abort drops everything, including a pending enable, with no pulse.
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            frame_d    = frame_in;
            byte_idx_d = '0;
            state_d    = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_ready) begin
            m_enable_d = 1'b1;
            timer_d    = '0;
            state_d    = ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          // Timeout is checked first so it wins over a same-cycle ready drop.
          if (timer_q == ACK_LAST) begin
            error_d = 1'b1;
            state_d = ST_ERROR;
          end else if (!m_ready) begin
            timer_d = '0;
            state_d = ST_WAIT_DONE;
          end else begin
            timer_d = timer_sat;
          end
        end
        ST_WAIT_DONE: begin
          if (timer_q == XFER_LAST) begin
            error_d = 1'b1;
            state_d = ST_ERROR;
          end else if (m_ready) begin
            if (byte_idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              byte_idx_d = byte_idx_q + IDX_W'(1);
              state_d    = ST_ISSUE;
            end
          end else begin
            timer_d = timer_sat;
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        ST_ERROR: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    busy_d    = (state_d != ST_IDLE);
    frame_ext = '0;
    frame_ext[FRAME_W-1:0] = frame_d;
    m_data_d  = byte_sel(frame_ext, int'(byte_idx_d), NBYTES);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      // NOTE: the frame register is cleared as well so m_data reads zero
      // after reset instead of stale data from an earlier frame.
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      byte_idx_q <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      m_enable_q <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      byte_idx_q <= byte_idx_d;
      timer_q    <= timer_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      m_enable_q <= m_enable_d;
      m_data_q   <= m_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign byte_idx = byte_idx_q;
  assign m_enable = m_enable_q;
  assign m_data   = m_data_q;
  assign m_addr   = SLAVE_ADDR;
  assign m_rw     = 1'b0;

endmodule

// File: tb/tb_i2c_frame_sequencer.sv
// Self-checking bench: randomized frames against a bus-functional I2C master
// and a cycle-count model derived from the per-byte handshake rules.
module tb_i2c_frame_sequencer;

  localparam int         NB      = 13;
  localparam int         IW      = $clog2(NB);
  localparam int         FW      = 8 * NB;
  localparam int         ACK_TO  = 64;
  localparam int         XFER_TO = 4096;
  localparam logic [6:0] ADDR    = 7'd7;

  logic          clk, rst, start, abort, m_ready;
  logic          busy, done, error, m_rw, m_enable;
  logic [FW-1:0] frame_in;
  logic [IW-1:0] byte_idx;
  logic [6:0]    m_addr;
  logic [7:0]    m_data;

  i2c_frame_sequencer #(
    .NBYTES      (NB),
    .SLAVE_ADDR  (ADDR),
    .ACK_TIMEOUT (ACK_TO),
    .XFER_TIMEOUT(XFER_TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .frame_in(frame_in),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .byte_idx(byte_idx),
    .m_addr  (m_addr),
    .m_data  (m_data),
    .m_rw    (m_rw),
    .m_enable(m_enable),
    .m_ready (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor records and bus-functional master state.
  int         cyc;
  int         en_cyc[$];
  logic [7:0] en_data[$];
  int         en_idx[$];
  int         done_cyc[$];
  int         err_cyc[$];
  int         err_idx[$];
  int         bfm_t;      // cycles the master holds ready low per byte
  int         low_cnt;
  bit         pend;
  int         ignore_n;   // byte index whose enable the master ignores

  task automatic clear_mon();
    en_cyc.delete(); en_data.delete(); en_idx.delete();
    done_cyc.delete(); err_cyc.delete(); err_idx.delete();
  endtask

  // One clock: sample outputs mid-cycle, then advance the master model.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (low_cnt > 0) begin
      low_cnt--;
      if (low_cnt == 0) m_ready = 1'b1;
    end
    if (pend) begin
      pend    = 1'b0;
      m_ready = 1'b0;
      low_cnt = bfm_t;
    end
    if (m_enable) begin
      en_cyc.push_back(cyc);
      en_data.push_back(m_data);
      en_idx.push_back(int'(byte_idx));
      if (int'(byte_idx) != ignore_n) pend = 1'b1;
    end
    if (done) done_cyc.push_back(cyc);
    if (error) begin
      err_cyc.push_back(cyc);
      err_idx.push_back(int'(byte_idx));
    end
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < NB; i++) f = {f[FW-9:0], 8'($urandom)};
    return f;
  endfunction

  // Byte i of the frame as transmitted: most significant byte goes first.
  function automatic logic [7:0] nth_byte(input logic [FW-1:0] f, input int i);
    return 8'(f >> (8 * (NB - 1 - i)));
  endfunction

  task automatic check_reset(input string pfx);
    check({pfx, ".busy"},     busy,     0);
    check({pfx, ".done"},     done,     0);
    check({pfx, ".error"},    error,    0);
    check({pfx, ".m_enable"}, m_enable, 0);
    check({pfx, ".m_data"},   m_data,   0);
    check({pfx, ".byte_idx"}, byte_idx, 0);
    check({pfx, ".m_addr"},   m_addr,   ADDR);
    check({pfx, ".m_rw"},     m_rw,     0);
  endtask

  // Full frame: t = master low time per byte, pre = initial ready-low cycles,
  // disturb = scramble frame_in and pulse start while busy.
  task automatic run_frame(input logic [FW-1:0] frame, input int t, input int pre,
                           input bit disturb, input string name);
    int sc, k, budget, first_exp, n;
    clear_mon();
    bfm_t    = t;
    ignore_n = -1;
    if (pre > 0) begin
      m_ready = 1'b0;
      low_cnt = pre;
    end
    frame_in = frame;
    start    = 1'b1;
    sc       = cyc;
    step();
    start  = 1'b0;
    k      = 0;
    budget = NB * (t + 3) + pre + 50;
    while (done_cyc.size() == 0 && err_cyc.size() == 0 && k < budget) begin
      if (disturb) begin
        frame_in = rand_frame();
        start    = (k == 20);
      end
      step();
      k++;
    end
    start = 1'b0;
    check({name, ".finished"}, (k < budget), 1);
    step();
    check({name, ".busy_after_done"}, busy, 0);

    // First enable waits for ISSUE (start+2) and for the first ready-high cycle.
    first_exp = sc + 1 + ((pre > 1) ? pre : 1);
    check({name, ".n_enable"}, en_cyc.size(), NB);
    n = (en_cyc.size() < NB) ? en_cyc.size() : NB;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.data[%0d]", name, i), en_data[i], nth_byte(frame, i));
      check($sformatf("%s.idx[%0d]", name, i), en_idx[i], i);
      check($sformatf("%s.en_cycle[%0d]", name, i), en_cyc[i] - sc, first_exp - sc + i * (t + 3));
    end
    check({name, ".n_done"}, done_cyc.size(), 1);
    check({name, ".n_error"}, err_cyc.size(), 0);
    if (done_cyc.size() > 0)
      check({name, ".frame_time"}, done_cyc[0] - sc + 1, NB * (t + 3) + 2 + (first_exp - (sc + 2)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] f;
    int k;
    rst = 1'b0; start = 1'b0; abort = 1'b0; frame_in = '0; m_ready = 1'b1;
    low_cnt = 0; pend = 1'b0; cyc = 0; ignore_n = -1; bfm_t = 20;

    step(); step();
    check_reset("por");
    rst = 1'b1;
    step();

    // Nominal frame 0x0102..0D with a 20-cycle master.
    f = '0;
    for (int i = 0; i < NB; i++) f = {f[FW-9:0], 8'(i + 1)};
    run_frame(f, 20, 0, 1'b0, "nominal");

    // Randomized frames and master timing, with frame_in scrambled and
    // start pulsed mid-frame.
    for (int r = 0; r < 4; r++)
      run_frame(rand_frame(), int'($urandom_range(2, 30)), int'($urandom_range(0, 3)), 1'b1,
                $sformatf("rand%0d", r));

    // Ready held low for 50 cycles before the first byte.
    run_frame(rand_frame(), 20, 50, 1'b0, "ready_low");

    // Ack timeout: master ignores the enable for byte 4.
    clear_mon();
    ignore_n = 4; bfm_t = 10;
    frame_in = rand_frame(); start = 1'b1;
    step(); start = 1'b0;
    k = 0;
    while (err_cyc.size() == 0 && done_cyc.size() == 0 && k < 2000) begin step(); k++; end
    check("ack.n_error", err_cyc.size(), 1);
    check("ack.n_enable", en_cyc.size(), 5);
    if (err_cyc.size() > 0 && en_cyc.size() == 5) begin
      check("ack.error_cycle", err_cyc[0] - en_cyc[4], ACK_TO);
      check("ack.error_idx", err_idx[0], 4);
    end
    step();
    check("ack.busy", busy, 0);
    check("ack.n_done", done_cyc.size(), 0);
    repeat (5) step();
    check("ack.idx_held", byte_idx, 4);
    ignore_n = -1;

    // Transfer timeout: ready stays low for 5000 cycles on byte 0.
    clear_mon();
    bfm_t = 5000;
    frame_in = rand_frame(); start = 1'b1;
    step(); start = 1'b0;
    k = 0;
    while (err_cyc.size() == 0 && done_cyc.size() == 0 && k < 4400) begin step(); k++; end
    check("xfer.n_error", err_cyc.size(), 1);
    if (err_cyc.size() > 0 && en_cyc.size() > 0) begin
      check("xfer.error_cycle", err_cyc[0] - en_cyc[0], 2 + XFER_TO);
      check("xfer.error_idx", err_idx[0], 0);
    end
    k = 0;
    while (!m_ready && k < 1500) begin step(); k++; end
    repeat (10) step();
    check("xfer.ready_back", m_ready, 1);
    check("xfer.single_error", err_cyc.size(), 1);
    check("xfer.n_done", done_cyc.size(), 0);
    check("xfer.n_enable", en_cyc.size(), 1);
    check("xfer.busy", busy, 0);
    bfm_t = 20;

    // Abort inside byte 7's transfer, then restart with a new frame.
    clear_mon();
    frame_in = rand_frame(); start = 1'b1;
    step(); start = 1'b0;
    k = 0;
    while (en_cyc.size() < 8 && k < 400) begin step(); k++; end
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    check("abort.busy", busy, 0);
    check("abort.m_enable", m_enable, 0);
    k = 0;
    while (!m_ready && k < 100) begin step(); k++; end
    repeat (30) step();
    check("abort.n_done", done_cyc.size(), 0);
    check("abort.n_error", err_cyc.size(), 0);
    check("abort.n_enable", en_cyc.size(), 8);
    run_frame(rand_frame(), 15, 0, 1'b0, "restart");

    // Reset while waiting in ISSUE.
    clear_mon();
    f = rand_frame();
    f[FW-1 -: 8] = 8'hA5;
    m_ready = 1'b0; low_cnt = 40;
    frame_in = f; start = 1'b1;
    step(); start = 1'b0;
    repeat (5) step();
    check("rst.busy_before", busy, 1);
    check("rst.m_data_before", m_data, 8'hA5);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_reset("rst_issue");
    k = 0;
    while (!m_ready && k < 100) begin step(); k++; end
    repeat (5) step();
    check("rst.n_enable", en_cyc.size(), 0);
    run_frame(rand_frame(), 5, 0, 1'b1, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
